// File: rtl/aes_key_pkg.sv
// Shared types, constant tables and block/column helpers for the AES-128 key schedule.
// Blocks are row-major: byte (row i, col j) lives at bits [32*i+8*j +: 8].
package aes_key_pkg;

   typedef logic [0:31]  word_t;
   typedef logic [0:127] block_t;

   localparam int NR_AES128 = 10;
   localparam int NUM_KEYS  = NR_AES128 + 1;

   typedef enum logic {
      ST_IDLE,
      ST_EXPAND
   } state_t;

   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   localparam logic [0:2047] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [10:0] base;
      base = {x, 3'b000};
      return SBOX_TBL[base +: 8];
   endfunction

   // Rounds outside 1..10 contribute no constant.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      v = 8'h00;
      if (r >= 4'd1 && r <= 4'd10) v = RCON[r];
      return v;
   endfunction

   function automatic word_t col_get(input block_t b, input int j);
      word_t w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = b[32*i + 8*j +: 8];
      return w;
   endfunction

   function automatic block_t col_put(input block_t b, input int j, input word_t w);
      block_t r;
      r = b;
      for (int i = 0; i < 4; i++) r[32*i + 8*j +: 8] = w[8*i +: 8];
      return r;
   endfunction

endpackage

// File: rtl/aes_key_schedule_round.sv
// One AES-128 key-expansion step: previous round key in, next round key out.
module aes_key_round
   import aes_key_pkg::*;
(
   input  block_t     prev_key,
   input  logic [3:0] round_idx,
   output block_t     next_key
);

   word_t w0, w1, w2, w3, rot, t, n0, n1, n2, n3;

   always_comb begin
      w0  = col_get(prev_key, 0);
      w1  = col_get(prev_key, 1);
      w2  = col_get(prev_key, 2);
      w3  = col_get(prev_key, 3);
      rot = {w3[8:31], w3[0:7]};
      t   = {sbox(rot[0:7]), sbox(rot[8:15]), sbox(rot[16:23]), sbox(rot[24:31])}
            ^ {rcon(round_idx), 24'h000000};
      n0  = w0 ^ t;
      n1  = w1 ^ n0;
      n2  = w2 ^ n1;
      n3  = w3 ^ n2;
      next_key = '0;
      next_key = col_put(next_key, 0, n0);
      next_key = col_put(next_key, 1, n1);
      next_key = col_put(next_key, 2, n2);
      next_key = col_put(next_key, 3, n3);
   end

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key schedule: one round key per clock into an 11-entry register
// file, readable by index as soon as each slot is written.
module aes_key_schedule
   import aes_key_pkg::*;
#(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [0:127] key_in,
   input  logic         key_load,
   output logic         ready,
   output logic         keys_valid,
   input  logic [3:0]   rk_idx,
   output logic [0:127] rk_out,
   output logic         rk_avail
);

   if (NR != NR_AES128) begin : g_bad_nr
      $error("aes_key_schedule: only NR=10 (AES-128) is supported");
   end

   localparam logic [3:0] LAST = 4'(NR);

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  ready_q, ready_d;
   logic                  keys_valid_q, keys_valid_d;
   logic [NUM_KEYS-1:0]   written_q, written_d;
   block_t                slot_q [NUM_KEYS];
   block_t                slot_d [NUM_KEYS];
   logic [3:0]            prev_idx;
   block_t                round_key;

   // cnt is 0 only in IDLE, where the round output is not used.
   assign prev_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;

   aes_key_round u_round (
      .prev_key  (slot_q[prev_idx]),
      .round_idx (cnt_q),
      .next_key  (round_key)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ready_d      = ready_q;
      keys_valid_d = keys_valid_q;
      written_d    = written_q;
      slot_d       = slot_q;
      case (state_q)
         ST_IDLE: begin
            if (key_load) begin
               slot_d[0]    = key_in;
               written_d    = {{(NUM_KEYS-1){1'b0}}, 1'b1};
               cnt_d        = 4'd1;
               keys_valid_d = 1'b0;
               ready_d      = 1'b0;
               state_d      = ST_EXPAND;
            end
         end
         ST_EXPAND: begin
            slot_d[cnt_q]    = round_key;
            written_d[cnt_q] = 1'b1;
            if (cnt_q == LAST) begin
               keys_valid_d = 1'b1;
               ready_d      = 1'b1;
               cnt_d        = 4'd0;
               state_d      = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         ready_q      <= 1'b1;
         keys_valid_q <= 1'b0;
         written_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ready_q      <= ready_d;
         keys_valid_q <= keys_valid_d;
         written_q    <= written_d;
      end
   end

   // Key storage is deliberately not reset; the written flags gate its visibility.
   always_ff @(posedge clk) begin
      slot_q <= slot_d;
   end

   always_comb begin
      rk_avail = 1'b0;
      rk_out   = '0;
      if (rk_idx <= LAST) begin
         rk_avail = written_q[rk_idx];
         rk_out   = slot_q[rk_idx];
      end
   end

   assign ready      = ready_q;
   assign keys_valid = keys_valid_q;

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
Sequential AES-128 key schedule. It accepts a cipher key and iterates the one-round key-expansion function once per clock, producing round keys 1..10. All 11 round keys are held in a register file. The cipher datapath reads them by round index. The block sits directly upstream of the round/AddRoundKey stages. It lets round 0 start as soon as the cipher key is loaded, without waiting for the full schedule.

Parameters:
NR, 10, number of expansion rounds; only 10 (AES-128) is supported, any other value is an elaboration error.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
key_in  input  [0:127]  cipher key, row-major state layout: byte (row i, col j) at bits [32*i+8*j +: 8]
key_load  input  1  load request; accepted only when ready=1
ready  output  1  block can accept key_load
keys_valid  output  1  all round keys 0..10 stored and stable
rk_idx  input  [3:0]  round-key read index, 0..10
rk_out  output  [0:127]  round key rk_idx, same layout as key_in
rk_avail  output  1  slot rk_idx already written for the current key

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - FSM = IDLE, cnt = 0.
  - ready = 1, keys_valid = 0.
  - All slot-written flags = 0, so rk_avail = 0.
  - Storage is not reset and rk_out is don't-care. The bench must gate rk_out on rk_avail.
- FSM states: IDLE, EXPAND.
- IDLE:
  - ready = 1.
  - On key_load=1 at clock edge E0: slot[0] <= key_in; written = 11'b1; cnt <= 1; keys_valid <= 0; go EXPAND.
- EXPAND:
  - ready = 0.
  - Each edge: slot[cnt] <= round_fn(slot[cnt-1], RCON[cnt]); written[cnt] <= 1; cnt <= cnt+1.
  - On the edge writing cnt=10: keys_valid <= 1; go IDLE; cnt <= 0.
- Timing:
  - Round key r is readable (rk_avail=1) after edge E0+r.
  - keys_valid rises after E0+10; ready is low for exactly 10 cycles.
- Round function:
  - Operates on the 4 column words of the previous key.
  - t = SubWord(RotWord(w3)) ^ RCON[r].
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36 in the top byte.
- Read port:
  - Combinational: rk_out = slot[rk_idx].
  - rk_avail = (rk_idx <= 10) && written[rk_idx].
  - For rk_idx 11..15: rk_avail = 0 and rk_out = 0.
- Boundary conditions:
  - key_load while ready=0 is ignored, with no effect on the schedule in progress.
  - key_load in IDLE while keys_valid=1 starts a new schedule. keys_valid drops and written clears (except slot 0) on E0; the old keys are unavailable from then on.
  - rst asserted mid-EXPAND aborts on that edge: IDLE, keys_valid=0, written=0.
  - rst and key_load on the same edge: reset wins.
  - key_in is sampled only at E0; later changes have no effect.

Decomposition:
- Shared package aes_key_pkg holds:
  - typedef word_t [0:31] and typedef block_t [0:127];
  - the RCON table indexed 1..10;
  - the S-box table;
  - col_get/col_put functions converting between row-major block layout and column words.
- One combinational sub-module, aes_key_round. Inputs: prev key block, round index 1..10. Output: next round-key block. It is instantiated once and fed by slot[cnt-1].
- The top level contains the FSM, counter, 11x128 storage, written flags and read mux.

Test Plan:
- Vector check, FIPS-197 A.1. Load key 2b7e1516 28aed2a6 abf71588 09cf4f3c (column words), converted to row-major.
  - rk_idx=1 after E0+1: a0fafe17 88542cb1 23a33939 2a6c7605.
  - rk_idx=10 after E0+10: d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - keys_valid rises exactly 10 cycles after acceptance.
- Progressive availability: sweep rk_idx each cycle during EXPAND. rk_avail must be 1 exactly for indices <= cycles since E0, and rk_idx=0 must return key_in from E0+1.
- Ignored load: pulse key_load with a different key at E0+4. ready stays 0, and final keys still match the first vector.
- Reset mid-operation: assert rst at E0+5 for 1 cycle. Then ready=1, keys_valid=0 and rk_avail=0 for all indices. A fresh load of the all-zero key gives round-10 words b4ef5bcb 3e92e211 23e951cf 6f8f188e.
- Reload after completion: with keys_valid=1, load a new key. keys_valid drops the next cycle, rk_avail(5)=0 until E0+5, and the new schedule is correct.
- Out-of-range read: rk_idx=11..15 gives rk_avail=0 and rk_out=0 in all states.
